// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result handshake bundle for the multi-cycle ALU.
//   master: producer/consumer side (drives in_valid, op, in1, in2, carry_in, out_ready)
//   slave : ALU side (drives in_ready, out_valid, result, hi, carry_out, overflow, zero)
// Signals:
//   in_valid/in_ready   - operation handshake
//   op[2:0]             - 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOR, 110 MUL, 111 DIV/reserved
//   in1, in2, carry_in  - operands; carry_in only used by ADD
//   out_valid/out_ready - result handshake
//   result, hi          - primary result / MUL high word or DIV remainder
//   carry_out, overflow, zero - status flags
interface alu_mc_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, op, in1, in2, carry_in, out_ready,
        input  in_ready, out_valid, result, hi, carry_out, overflow, zero
    );

    modport slave (
        input  in_valid, op, in1, in2, carry_in, out_ready,
        output in_ready, out_valid, result, hi, carry_out, overflow, zero
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the MIPS datapath.
//   Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR) produce registered results one
//   edge after accept; MUL (and DIV when ALU_DIV_EN is defined) iterate WIDTH
//   times before presenting the result.
// Optional feature macro: ALU_DIV_EN
//   defined   - op 111 is an unsigned restoring divide (result=quotient, hi=remainder)
//   undefined - op 111 is a 1-cycle op returning zero; no divider logic
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - alu_mc_if.slave handshake/operand/result bundle
// Parameters:
//   WIDTH - operand/result width (>= 4)
//   CNT_W - iteration counter width, 2**CNT_W > WIDTH
module alu_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic     clk,
    input logic     reset,
    alu_mc_if.slave bus
);

    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH:0]   mul_sum;
    logic             last_iter;

    assign bus.in_ready  = (state_q == S_IDLE) && !reset;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.hi        = hi_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = (result_q == '0);

    // Single-cycle arithmetic straight from the bus operands at accept time.
    always_comb begin
        add_sum  = {1'b0, bus.in1} + {1'b0, bus.in2} + {{WIDTH{1'b0}}, bus.carry_in};
        sub_diff = {1'b0, bus.in1} + {1'b0, ~bus.in2} + {{WIDTH{1'b0}}, 1'b1};
        add_ovf  = (bus.in1[MSB] == bus.in2[MSB]) && (add_sum[MSB] != bus.in1[MSB]);
        sub_ovf  = (bus.in1[MSB] != bus.in2[MSB]) && (sub_diff[MSB] != bus.in1[MSB]);
    end

    // Shift-add multiply step: {hi_q, result_q} is the partial product with the
    // unconsumed multiplier bits in the low end of result_q.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (result_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    end

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef ALU_DIV_EN
    // Restoring divide step: hi_q holds the partial remainder, result_q shifts
    // dividend bits out of the top and quotient bits in at the bottom.
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_trial;
    logic           div_ge;

    always_comb begin
        div_shift = {hi_q, result_q[MSB]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_trial = div_shift - {1'b0, opb_q};
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opb_d    = opb_q;
        result_d = result_q;
        hi_d     = hi_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    opb_d   = bus.in2;
                    hi_d    = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    case (bus.op)
                        3'b000: result_d = bus.in1 & bus.in2;
                        3'b001: result_d = bus.in1 | bus.in2;
                        3'b010: begin
                            result_d = add_sum[MSB:0];
                            carry_d  = add_sum[WIDTH];
                            ovf_d    = add_ovf;
                        end
                        3'b011: begin
                            result_d = sub_diff[MSB:0];
                            carry_d  = sub_diff[WIDTH];
                            ovf_d    = sub_ovf;
                        end
                        3'b100: result_d = {{(WIDTH-1){1'b0}}, sub_diff[MSB] ^ sub_ovf};
                        3'b101: result_d = ~(bus.in1 | bus.in2);
                        3'b110: begin
                            result_d = bus.in1;
                            state_d  = S_MUL;
                        end
                        default: begin
`ifdef ALU_DIV_EN
                            if (bus.in2 == '0) begin
                                result_d = '1;
                                hi_d     = bus.in1;
                            end else begin
                                result_d = bus.in1;
                                state_d  = S_DIV;
                            end
`else
                            result_d = '0;
`endif
                        end
                    endcase
                end
            end

            S_MUL: begin
                {hi_d, result_d} = {mul_sum, result_q[MSB:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end

            S_DIV: begin
`ifdef ALU_DIV_EN
                hi_d     = div_ge ? div_trial[MSB:0] : div_shift[MSB:0];
                result_d = {result_q[MSB-1:0], div_ge};
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d = S_DONE;
                end
`else
                state_d = S_IDLE;
`endif
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (WIDTH=32).
// Directed vector table, randomized operations against an arithmetic
// reference model, plus hand sequences for held in_valid and reset mid-MUL.
module tb_alu_mc;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        int          hold;
        logic [31:0] res;
        logic [31:0] hi;
        logic        co;
        logic        ov;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, output logic [31:0] res, output logic [31:0] hi,
                                  output logic co, output logic ov, output int lat);
        longint      sa, sb, s;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0; hi = '0; co = 1'b0; ov = 1'b0; lat = 1;
        case (op)
            3'd0: res = a & b;
            3'd1: res = a | b;
            3'd2: begin
                p   = 64'(a) + 64'(b) + 64'(cin);
                res = p[31:0];
                co  = p[32];
                s   = sa + sb + longint'(cin);
                ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd3: begin
                res = a - b;
                co  = (a >= b);
                s   = sa - sb;
                ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd4: res = (sa < sb) ? 32'd1 : 32'd0;
            3'd5: res = ~(a | b);
            3'd6: begin
                p   = 64'(a) * 64'(b);
                res = p[31:0];
                hi  = p[63:32];
                lat = 33;
            end
            default: begin
`ifdef ALU_DIV_EN
                if (b == 0) begin
                    res = 32'hFFFF_FFFF;
                    hi  = a;
                end else begin
                    res = a / b;
                    hi  = a % b;
                    lat = 33;
                end
`endif
            end
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input int hold,
                          output logic [31:0] res, output logic [31:0] hi, output logic co,
                          output logic ov, output logic z, output int lat,
                          output bit busy_ok, output bit stable_ok, output bit exit_ok);
        int guard;
        busy_ok = 1'b1; stable_ok = 1'b1; exit_ok = 1'b1;
        @(negedge clk);
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bus.op = op; bus.in1 = a; bus.in2 = b; bus.carry_in = cin;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op = 3'($urandom); bus.in1 = $urandom; bus.in2 = $urandom; bus.carry_in = 1'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.out_valid && bus.in_ready) busy_ok = 1'b0;
        end while (!bus.out_valid && lat < 200);
        res = bus.result; hi = bus.hi; co = bus.carry_out; ov = bus.overflow; z = bus.zero;
        if (bus.in_ready) stable_ok = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            if (!bus.out_valid || bus.in_ready || bus.result !== res || bus.hi !== hi ||
                bus.carry_out !== co || bus.overflow !== ov || bus.zero !== z)
                stable_ok = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        if (bus.out_valid || !bus.in_ready) exit_ok = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic cin, input int hold,
                            input logic [31:0] e_res, input logic [31:0] e_hi, input logic e_co,
                            input logic e_ov, input logic e_z, input int e_lat);
        logic [31:0] res, hi;
        logic        co, ov, z;
        int          lat;
        bit          busy_ok, stable_ok, exit_ok;
        run_op(op, a, b, cin, hold, res, hi, co, ov, z, lat, busy_ok, stable_ok, exit_ok);
        chk({tag, ".result"}, 64'(res), 64'(e_res));
        chk({tag, ".hi"}, 64'(hi), 64'(e_hi));
        chk({tag, ".carry_out"}, 64'(co), 64'(e_co));
        chk({tag, ".overflow"}, 64'(ov), 64'(e_ov));
        chk({tag, ".zero"}, 64'(z), 64'(e_z));
        chk({tag, ".latency"}, 64'(lat), 64'(e_lat));
        chk({tag, ".busy_in_ready_low"}, 64'(busy_ok), 64'd1);
        chk({tag, ".done_stable"}, 64'(stable_ok), 64'd1);
        chk({tag, ".done_exit"}, 64'(exit_ok), 64'd1);
    endtask

    task automatic add_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input int hold, input logic [31:0] res,
                           input logic [31:0] hi, input logic co, input logic ov,
                           input logic z, input int lat);
        vec_t v;
        v = '{op, a, b, cin, hold, res, hi, co, ov, z, lat};
        vecs.push_back(v);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, e_res, e_hi;
        logic [2:0]  op;
        logic        cin, e_co, e_ov;
        int          e_lat;
        bit          seen;

        add_vec(3'b000, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 0, 32'h00000000, 32'h0, 1'b0, 1'b0, 1'b1, 1);
        add_vec(3'b001, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        add_vec(3'b010, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        add_vec(3'b011, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 0, 32'h4B4B4B4B, 32'h0, 1'b1, 1'b1, 1'b0, 1);
        add_vec(3'b100, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 0, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        add_vec(3'b010, 32'h7FFFFFFF, 32'h00000000, 1'b1, 0, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1);
        add_vec(3'b011, 32'h12345678, 32'h12345679, 1'b1, 0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        add_vec(3'b101, 32'h0F0F0F0F, 32'h00FF00FF, 1'b0, 0, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        add_vec(3'b110, 32'h00010000, 32'h00010000, 1'b0, 5, 32'h00000000, 32'h1, 1'b0, 1'b0, 1'b1, 33);
        add_vec(3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33);
`ifdef ALU_DIV_EN
        add_vec(3'b111, 32'h00000064, 32'h00000007, 1'b0, 0, 32'h0000000E, 32'h2, 1'b0, 1'b0, 1'b0, 33);
        add_vec(3'b111, 32'h12345678, 32'h00000000, 1'b0, 0, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0, 1'b0, 1);
`else
        add_vec(3'b111, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 0, 32'h00000000, 32'h0, 1'b0, 1'b0, 1'b1, 1);
`endif

        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0;
        bus.in1 = '0; bus.in2 = '0; bus.carry_in = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset.in_ready", 64'(bus.in_ready), 64'd0);
        chk("reset.result", 64'(bus.result), 64'd0);
        chk("reset.hi", 64'(bus.hi), 64'd0);
        chk("reset.flags", 64'({bus.carry_out, bus.overflow}), 64'd0);
        chk("reset.zero", 64'(bus.zero), 64'd1);
        reset = 1'b0;
        #1;
        chk("reset.release_in_ready", 64'(bus.in_ready), 64'd1);

        foreach (vecs[i]) begin
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
                     vecs[i].hold, vecs[i].res, vecs[i].hi, vecs[i].co, vecs[i].ov,
                     vecs[i].z, vecs[i].lat);
        end

        // in_valid held through DONE: second op must wait for the DONE exit cycle.
        @(negedge clk);
        bus.op = 3'b000; bus.in1 = 32'h0F0F0F0F; bus.in2 = 32'h00FF00FF; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.op = 3'b001;
        @(negedge clk);
        chk("hold.first_valid", 64'(bus.out_valid), 64'd1);
        chk("hold.first_result", 64'(bus.result), 64'h000F000F);
        chk("hold.first_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("hold.exit_valid", 64'(bus.out_valid), 64'd0);
        chk("hold.exit_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("hold.second_valid", 64'(bus.out_valid), 64'd1);
        chk("hold.second_result", 64'(bus.result), 64'h0FFF0FFF);
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Reset partway through a MUL.
        bus.op = 3'b110; bus.in1 = 32'h00010000; bus.in2 = 32'h00000003; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort.busy_in_ready", 64'(bus.in_ready), 64'd0);
        reset = 1'b1;
        #1;
        chk("abort.reset_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("abort.out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort.result", 64'({bus.hi, bus.result}), 64'd0);
        chk("abort.zero", 64'(bus.zero), 64'd1);
        reset = 1'b0;
        #1;
        chk("abort.in_ready_after", 64'(bus.in_ready), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("abort.no_output", 64'(seen), 64'd0);

        // Randomized operations against the reference model.
        for (int n = 0; n < 150; n++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = a;
                2: b = '0;
                default: b = 32'($urandom_range(1, 15));
            endcase
            cin = 1'($urandom_range(0, 1));
            model(op, a, b, cin, e_res, e_hi, e_co, e_ov, e_lat);
            check_op($sformatf("rnd%0d_op%0d", n, op), op, a, b, cin,
                     int'($urandom_range(0, 3)), e_res, e_hi, e_co, e_ov,
                     (e_res == 32'd0), e_lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the MIPS datapath; the next generation of the combinational 32-bit AND/OR/ADD/SUB ALU.
- Adds registered outputs, valid/ready handshakes on both sides, SLT and NOR, status flags, and an iterative unsigned multiplier, optionally a divider.
- Sits between the register-read stage and writeback; HI/LO writes come from the hi and result outputs.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept an operation.
- op  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOR, 110 MUL, 111 DIV/reserved.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- carry_in  input  1  carry into ADD; ignored by all other ops.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  primary result (MUL low word, DIV quotient).
- hi  output  WIDTH  MUL high word, DIV remainder; 0 for other ops.
- carry_out  output  1  ADD/SUB carry out; 0 for other ops.
- overflow  output  1  signed overflow for ADD/SUB; 0 for other ops.
- zero  output  1  result == 0, all ops.

Behaviour:
- Reset (sampled at a clk edge while reset=1):
  - state=IDLE; out_valid, result, hi, carry_out, overflow, counter all 0; zero=1.
  - in_ready=0 while reset is high.
  - Reset aborts any in-flight MUL/DIV with no output.
- States and transitions:
  - IDLE: in_ready=1. An operation is accepted on an edge with in_valid=1 in IDLE; operands and op are latched.
  - Single-cycle op accepted: go to DONE; outputs valid one edge after the accept edge.
  - op=110 accepted: go to MUL.
  - op=111 accepted with ALU_DIV_EN defined and in2!=0: go to DIV.
  - MUL/DIV: run exactly WIDTH iterations, one per edge, then go to DONE. out_valid rises WIDTH+1 edges after the accept edge.
  - DONE: out_valid=1, in_ready=0. Outputs stay stable until an edge with out_ready=1, then go to IDLE.
- Throughput: no new accept in the DONE-exit cycle, so at most one operation per 2 cycles.
- ADD: {carry_out,result} = in1 + in2 + carry_in. overflow is set when the operand signs match and the result sign differs.
- SUB: in1 + ~in2 + 1, carry_in ignored. carry_out=1 means no borrow. overflow is set when the operand signs differ and the result sign differs from in1.
- SLT: result = 1 if in1 < in2 signed (sign of difference XOR overflow), else 0. carry_out=0 and overflow=0.
- AND/OR/NOR: bitwise; carry_out=0, overflow=0, hi=0.
- MUL: unsigned shift-add; {hi,result} = in1*in2, full 2*WIDTH product, no flags.
- zero reflects result only, never hi.
- Inputs that change while busy are ignored.
- in_valid=1 in DONE is held off, not dropped: in_ready=0 there, so the producer must keep in_valid asserted.

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined:
  - op 111 performs unsigned restoring division: result=quotient, hi=remainder, WIDTH iterations.
  - in2==0: skip iteration, go directly to DONE (1-cycle latency) with result all ones and hi=in1.
  - carry_out=0 and overflow=0 for all DIV results.
- Undefined:
  - op 111 is a 1-cycle op with result=0, hi=0, zero=1, other flags 0.
  - No divider logic is synthesised.

Test Plan:
- WIDTH=32, in1=A5A5A5A5, in2=5A5A5A5A, carry_in=0; ops AND/OR/ADD:
  - AND -> result=00000000, zero=1.
  - OR -> FFFFFFFF.
  - ADD -> FFFFFFFF, carry_out=0, overflow=0.
  - Each out_valid exactly 1 edge after accept.
- Same operands, SUB -> result=4B4B4B4B, carry_out=1, overflow=1. SLT -> result=1.
- ADD with 7FFFFFFF + 00000000 and carry_in=1 -> 80000000, overflow=1, carry_out=0.
- MUL 00010000 x 00010000 -> hi=00000001, result=00000000, zero=1, out_valid 33 edges after accept; in_ready=0 throughout.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and flags stable, in_ready=0. Raise out_ready -> IDLE next edge. Then assert reset mid-MUL (iteration 10) -> out_valid never rises, in_ready=1 on the edge after reset deasserts.
- ALU_DIV_EN:
  - 00000064 / 00000007 -> result=0000000E, hi=00000002.
  - Divide by zero with in1=12345678 -> result=FFFFFFFF, hi=12345678, 1-edge latency.
  - Without the macro, op 111 -> result=0, zero=1.
